alu_issue_stage: RTL

Pipeline stage between instruction decode and the execute-stage ALU complex. It accepts decoded R-type operations through a valid/ready handshake and registers the `Signal`/`dataA`/`dataB` bundle the ALU consumes. It tracks the multi-cycle MULTU so that MFHI/MFLO and back-to-back MULTU are held until the HI/LO result is stable. It also inserts bubbles and keeps a saturating stall counter.

---
 rtl/alu_issue_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage between decode and the execute ALU: registers the Signal/dataA/dataB
// bundle, holds HI/LO consumers behind an in-flight MULTU and counts stall cycles.
module alu_issue_stage #(
   parameter int unsigned   MUL_CYCLES = 32,
   parameter logic [5:0]    NOP_CODE   = 6'h3F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [5:0]  id_funct,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [4:0]  id_shamt,
   input  logic        ex_stall,
   output logic [5:0]  Signal,
   output logic [31:0] dataA,
   output logic [31:0] dataB,
   output logic        ex_valid,
   output logic        mul_busy,
   output logic        illegal_op,
   output logic [15:0] stall_cycles
);

   localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

   localparam logic [5:0] F_SLL   = 6'd0;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;
   localparam logic [5:0] F_MULTU = 6'd25;

   logic [CNT_W-1:0] busyCnt_r;
   logic [5:0]       signal_r;
   logic [31:0]      dataA_r;
   logic [31:0]      dataB_r;
   logic             exValid_r;
   logic             illegal_r;
   logic [15:0]      stallCnt_r;

   logic             hazard_s;
   logic             ready_s;
   logic             transfer_s;
   logic             supported_s;
   logic [31:0]      nextA_s;
   logic [31:0]      nextB_s;

   // HI/LO readers and a second MULTU must wait for the multiplier to drain.
   function automatic logic usesHiLo(input logic [5:0] funct);
      usesHiLo = (funct == F_MFHI) || (funct == F_MFLO) || (funct == F_MULTU);
   endfunction

   // Hazard detection and the combinational accept handshake.
   always_comb begin
      hazard_s   = (busyCnt_r != {CNT_W{1'b0}}) && usesHiLo(id_funct);
      ready_s    = !rst && !ex_stall && !hazard_s;
      transfer_s = id_valid && ready_s;
   end

   // Funct decode and operand mapping for the bundle loaded on transfer.
   always_comb begin
      supported_s = 1'b1;
      nextA_s     = 32'd0;
      nextB_s     = 32'd0;
      case (id_funct)
         6'd32, 6'd34, 6'd36, 6'd37, 6'd42, F_MULTU: begin
            nextA_s = id_rs_data;
            nextB_s = id_rt_data;
         end
         F_SLL: begin
            nextA_s = id_rt_data;
            nextB_s = {27'd0, id_shamt};
         end
         F_MFHI, F_MFLO: begin
            nextA_s = 32'd0;
            nextB_s = 32'd0;
         end
         default: supported_s = 1'b0;
      endcase
   end

   // Output bundle: load on transfer, bubble when idle or hazarded, hold on ex_stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         signal_r  <= NOP_CODE;
         dataA_r   <= 32'd0;
         dataB_r   <= 32'd0;
         exValid_r <= 1'b0;
      end else if (ex_stall) begin
         signal_r  <= signal_r;
         dataA_r   <= dataA_r;
         dataB_r   <= dataB_r;
         exValid_r <= exValid_r;
      end else if (transfer_s && supported_s) begin
         signal_r  <= id_funct;
         dataA_r   <= nextA_s;
         dataB_r   <= nextB_s;
         exValid_r <= 1'b1;
      end else begin
         signal_r  <= NOP_CODE;
         dataA_r   <= 32'd0;
         dataB_r   <= 32'd0;
         exValid_r <= 1'b0;
      end
   end

   // Illegal-op pulse: refreshed every edge so it lasts exactly one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_r <= 1'b0;
      end else begin
         illegal_r <= transfer_s && !supported_s;
      end
   end

   // Multiplier occupancy; keeps counting down through ex_stall since the multiplier runs freely.
   always_ff @(posedge clk) begin
      if (rst) begin
         busyCnt_r <= {CNT_W{1'b0}};
      end else if (transfer_s && (id_funct == F_MULTU)) begin
         busyCnt_r <= CNT_W'(MUL_CYCLES);
      end else if (busyCnt_r != {CNT_W{1'b0}}) begin
         busyCnt_r <= busyCnt_r - CNT_W'(1);
      end else begin
         busyCnt_r <= busyCnt_r;
      end
   end

   // Saturating count of cycles where decode offered an op that was refused.
   always_ff @(posedge clk) begin
      if (rst) begin
         stallCnt_r <= 16'd0;
      end else if (id_valid && !ready_s && (stallCnt_r != 16'hFFFF)) begin
         stallCnt_r <= stallCnt_r + 16'd1;
      end else begin
         stallCnt_r <= stallCnt_r;
      end
   end

   assign id_ready     = ready_s;
   assign Signal       = signal_r;
   assign dataA        = dataA_r;
   assign dataB        = dataB_r;
   assign ex_valid     = exValid_r;
   assign mul_busy     = (busyCnt_r != {CNT_W{1'b0}});
   assign illegal_op   = illegal_r;
   assign stall_cycles = stallCnt_r;

endmodule
